// File: rtl/repeated_sub_divider_if.sv
// repeated_sub_divider_if: start/done handshake, operands and results of the repeated-subtraction divider
interface repeated_sub_divider_if #(parameter int WIDTH = 16);
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic             div_by_zero;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    modport master (output start, dividend, divisor, input busy, done, div_by_zero, quotient, remainder);
    modport slave (input start, dividend, divisor, output busy, done, div_by_zero, quotient, remainder);
endinterface

// File: rtl/repeated_sub_divider.sv
// repeated_sub_divider: unsigned divider subtracting the divisor once per cycle until the remainder drops below it
module repeated_sub_divider #(
    parameter int WIDTH = 16
) (
    input logic                   clk,
    input logic                   rst_n,
    repeated_sub_divider_if.slave bus
);
    typedef enum logic [1:0] {IDLE, LOAD, SUB, DONE} state_t;
    state_t           state, state_d;
    logic [WIDTH-1:0] a, a_d, b, b_d, q, q_d;
    logic             dz, dz_d;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            a     <= '0;
            b     <= '0;
            q     <= '0;
            dz    <= 1'b0;
        end else begin
            state <= state_d;
            a     <= a_d;
            b     <= b_d;
            q     <= q_d;
            dz    <= dz_d;
        end
    end
    always_comb begin
        state_d = state;
        a_d     = a;
        b_d     = b;
        q_d     = q;
        dz_d    = dz;
        case (state)
            IDLE, DONE: if (bus.start) begin
                a_d     = bus.dividend;
                b_d     = bus.divisor;
                q_d     = '0;
                dz_d    = 1'b0;
                state_d = LOAD;
            end
            LOAD: if (b == '0) begin
                q_d     = '1;
                dz_d    = 1'b1;
                state_d = DONE;
            end else begin
                state_d = SUB;
            end
            SUB: if (a >= b) begin
                a_d = a - b;
                q_d = q + 1'b1;
            end else begin
                state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
    end
    assign bus.busy        = (state == LOAD) || (state == SUB);
    assign bus.done        = state == DONE;
    assign bus.div_by_zero = dz;
    assign bus.quotient    = q;
    assign bus.remainder   = a;
endmodule

// File: tb/tb_repeated_sub_divider.sv
// tb_repeated_sub_divider: randomized and directed checks of 16- and 8-bit dividers against an arithmetic model
module tb_repeated_sub_divider;
    logic clk = 1'b0;
    logic rst_n;
    int   tests = 0;
    int   fails = 0;
    always #5 clk = ~clk;

    repeated_sub_divider_if #(.WIDTH(16)) b16();
    repeated_sub_divider_if #(.WIDTH(8))  b8();
    repeated_sub_divider #(.WIDTH(16)) u16 (.clk(clk), .rst_n(rst_n), .bus(b16));
    repeated_sub_divider #(.WIDTH(8))  u8  (.clk(clk), .rst_n(rst_n), .bus(b8));

    function automatic void model(input int w, input int dd, input int dv,
                                  output logic [15:0] q, output logic [15:0] r, output int lat);
        q   = (dv == 0) ? 16'((1 << w) - 1) : 16'(dd / dv);
        r   = (dv == 0) ? 16'(dd) : 16'(dd % dv);
        lat = (dv == 0) ? 1 : dd / dv + 2;
    endfunction

    // callers are always 1 time unit after a rising edge; return just after the accepting edge E0
    task automatic go16(input logic [15:0] dd, input logic [15:0] dv);
        b16.start = 1'b1; b16.dividend = dd; b16.divisor = dv;
        @(posedge clk); #1;
        b16.start = 1'b0;
    endtask

    task automatic go8(input logic [7:0] dd, input logic [7:0] dv);
        b8.start = 1'b1; b8.dividend = dd; b8.divisor = dv;
        @(posedge clk); #1;
        b8.start = 1'b0;
    endtask

    task automatic wait16(output int n);
        n = 0;
        while (b16.done !== 1'b1 && n < 70000) begin
            @(posedge clk); #1; n++;
        end
    endtask

    task automatic wait8(output int n);
        n = 0;
        while (b8.done !== 1'b1 && n < 1000) begin
            @(posedge clk); #1; n++;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        b16.start = 1'b0; b16.dividend = '0; b16.divisor = '0;
        b8.start = 1'b0;  b8.dividend = '0;  b8.divisor = '0;
        repeat (2) @(posedge clk);
        #1;
        tests++;
        if ({b16.busy, b16.done, b16.div_by_zero, b16.quotient, b16.remainder} !== 35'd0) begin
            fails++; $display("FAIL reset16 got busy=%b done=%b dz=%b q=%0d r=%0d want all 0",
                b16.busy, b16.done, b16.div_by_zero, b16.quotient, b16.remainder);
        end
        tests++;
        if ({b8.busy, b8.done, b8.div_by_zero, b8.quotient, b8.remainder} !== 19'd0) begin
            fails++; $display("FAIL reset8 got busy=%b done=%b dz=%b q=%0d r=%0d want all 0",
                b8.busy, b8.done, b8.div_by_zero, b8.quotient, b8.remainder);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic;
        go16(16'd100, 16'd7);
        tests++;
        if (b16.busy !== 1'b1 || b16.done !== 1'b0) begin
            fails++; $display("FAIL basic_e0 got busy=%b done=%b want 1 0", b16.busy, b16.done);
        end
        for (int i = 1; i <= 16; i++) begin
            @(posedge clk); #1;
            tests++;
            if (b16.busy !== (i < 16) || b16.done !== (i == 16)) begin
                fails++; $display("FAIL basic_timing E%0d got busy=%b done=%b want %b %b",
                    i, b16.busy, b16.done, i < 16, i == 16);
            end
        end
        tests++;
        if (b16.quotient !== 16'd14 || b16.remainder !== 16'd2 || b16.div_by_zero !== 1'b0) begin
            fails++; $display("FAIL basic_result got q=%0d r=%0d dz=%b want 14 2 0",
                b16.quotient, b16.remainder, b16.div_by_zero);
        end
    endtask

    task automatic test_small;
        int n;
        go16(16'd5, 16'd9); wait16(n);
        tests++;
        if (n !== 2 || b16.quotient !== 16'd0 || b16.remainder !== 16'd5) begin
            fails++; $display("FAIL small_5_9 got lat=%0d q=%0d r=%0d want 2 0 5", n, b16.quotient, b16.remainder);
        end
        go16(16'd0, 16'd3); wait16(n);
        tests++;
        if (n !== 2 || b16.quotient !== 16'd0 || b16.remainder !== 16'd0) begin
            fails++; $display("FAIL small_0_3 got lat=%0d q=%0d r=%0d want 2 0 0", n, b16.quotient, b16.remainder);
        end
    endtask

    task automatic test_div_by_zero;
        int n;
        go16(16'd37, 16'd0); wait16(n);
        tests++;
        if (n !== 1 || b16.div_by_zero !== 1'b1 || b16.quotient !== 16'hFFFF || b16.remainder !== 16'd37) begin
            fails++; $display("FAIL dbz got lat=%0d dz=%b q=%h r=%0d want 1 1 ffff 37",
                n, b16.div_by_zero, b16.quotient, b16.remainder);
        end
        go16(16'd37, 16'd5);
        tests++;
        if (b16.done !== 1'b0 || b16.div_by_zero !== 1'b0) begin
            fails++; $display("FAIL dbz_clear got done=%b dz=%b want 0 0", b16.done, b16.div_by_zero);
        end
        wait16(n);
        tests++;
        if (n !== 9 || b16.quotient !== 16'd7 || b16.remainder !== 16'd2 || b16.div_by_zero !== 1'b0) begin
            fails++; $display("FAIL dbz_next got lat=%0d q=%0d r=%0d dz=%b want 9 7 2 0",
                n, b16.quotient, b16.remainder, b16.div_by_zero);
        end
    endtask

    task automatic test_width8;
        int n;
        go8(8'd255, 8'd1); wait8(n);
        tests++;
        if (n !== 257 || b8.quotient !== 8'd255 || b8.remainder !== 8'd0) begin
            fails++; $display("FAIL w8_255_1 got lat=%0d q=%0d r=%0d want 257 255 0", n, b8.quotient, b8.remainder);
        end
        go8(8'd255, 8'd255); wait8(n);
        tests++;
        if (n !== 3 || b8.quotient !== 8'd1 || b8.remainder !== 8'd0) begin
            fails++; $display("FAIL w8_255_255 got lat=%0d q=%0d r=%0d want 3 1 0", n, b8.quotient, b8.remainder);
        end
    endtask

    task automatic test_ignore_start;
        int n;
        go16(16'd100, 16'd7);
        repeat (4) begin @(posedge clk); #1; end
        b16.start = 1'b1; b16.dividend = 16'd9; b16.divisor = 16'd3;
        @(posedge clk); #1;
        b16.start = 1'b0;
        wait16(n);
        tests++;
        if (n + 5 !== 16 || b16.quotient !== 16'd14 || b16.remainder !== 16'd2) begin
            fails++; $display("FAIL ignore_busy got lat=%0d q=%0d r=%0d want 16 14 2", n + 5, b16.quotient, b16.remainder);
        end
        go16(16'd9, 16'd3);
        tests++;
        if (b16.done !== 1'b0 || b16.busy !== 1'b1) begin
            fails++; $display("FAIL from_done_e0 got done=%b busy=%b want 0 1", b16.done, b16.busy);
        end
        wait16(n);
        tests++;
        if (n !== 5 || b16.quotient !== 16'd3 || b16.remainder !== 16'd0) begin
            fails++; $display("FAIL from_done got lat=%0d q=%0d r=%0d want 5 3 0", n, b16.quotient, b16.remainder);
        end
    endtask

    task automatic test_reset_mid;
        int n;
        go16(16'd100, 16'd7);
        repeat (7) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        tests++;
        if ({b16.busy, b16.done, b16.div_by_zero, b16.quotient, b16.remainder} !== 35'd0) begin
            fails++; $display("FAIL reset_mid got busy=%b done=%b dz=%b q=%0d r=%0d want all 0",
                b16.busy, b16.done, b16.div_by_zero, b16.quotient, b16.remainder);
        end
        @(posedge clk); #1;
        tests++;
        if (b16.busy !== 1'b0 || b16.done !== 1'b0) begin
            fails++; $display("FAIL reset_idle got busy=%b done=%b want 0 0", b16.busy, b16.done);
        end
        go16(16'd20, 16'd6); wait16(n);
        tests++;
        if (n !== 5 || b16.quotient !== 16'd3 || b16.remainder !== 16'd2) begin
            fails++; $display("FAIL after_reset got lat=%0d q=%0d r=%0d want 5 3 2", n, b16.quotient, b16.remainder);
        end
    endtask

    task automatic test_back_to_back;
        int          dd, dv, n, lat;
        logic [15:0] eq, er;
        for (int k = 0; k < 25; k++) begin
            dd = int'($urandom_range(0, 65535));
            dv = int'($urandom_range(0, 65535));
            if (dv != 0 && dd / dv > 400) dv = dd / 400 + 1;
            if ($urandom_range(0, 7) == 0) dv = 0;
            model(16, dd, dv, eq, er, lat);
            go16(16'(dd), 16'(dv)); wait16(n);
            tests++;
            if (n !== lat || b16.quotient !== eq || b16.remainder !== er || b16.div_by_zero !== (dv == 0)) begin
                fails++; $display("FAIL rand16 %0d/%0d got lat=%0d q=%0d r=%0d dz=%b want %0d %0d %0d %b",
                    dd, dv, n, b16.quotient, b16.remainder, b16.div_by_zero, lat, eq, er, dv == 0);
            end
            @(posedge clk); #1;
            tests++;
            if (b16.done !== 1'b1 || b16.quotient !== eq || b16.remainder !== er) begin
                fails++; $display("FAIL hold16 got done=%b q=%0d r=%0d want 1 %0d %0d", b16.done, b16.quotient, b16.remainder, eq, er);
            end
        end
        for (int k = 0; k < 15; k++) begin
            dd = int'($urandom_range(0, 255));
            dv = int'($urandom_range(0, 255));
            if ($urandom_range(0, 7) == 0) dv = 0;
            model(8, dd, dv, eq, er, lat);
            go8(8'(dd), 8'(dv)); wait8(n);
            tests++;
            if (n !== lat || b8.quotient !== eq[7:0] || b8.remainder !== er[7:0] || b8.div_by_zero !== (dv == 0)) begin
                fails++; $display("FAIL rand8 %0d/%0d got lat=%0d q=%0d r=%0d dz=%b want %0d %0d %0d %b",
                    dd, dv, n, b8.quotient, b8.remainder, b8.div_by_zero, lat, eq[7:0], er[7:0], dv == 0);
            end
        end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_small;
        test_div_by_zero;
        test_width8;
        test_ignore_start;
        test_reset_mid;
        test_back_to_back;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
